spi_coeff_tx: RTL



---
 rtl/spi_coeff_tx_pkg.sv | 13 +
 rtl/spi_coeff_tx_if.sv | 12 +
 rtl/spi_coeff_tx_clk_tick.sv | 30 +++
 rtl/spi_coeff_tx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/spi_coeff_tx_pkg.sv
// Shared types and helpers for the SPI coefficient transmitter.
package fir_engine_pkg;

  typedef enum logic [2:0] {IDLE, SHIFT, NEXT, HOLD, GAP} spi_tx_state_t;

  localparam logic SPI_CS_ACTIVE = 1'b0;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_coeff_tx_if.sv
// Ready/valid coefficient stream between a word source and the SPI transmitter.
interface spi_coeff_tx_if #(
  parameter int DataWidth = 8
) ();
  logic                 sValid;
  logic [DataWidth-1:0] sData;
  logic                 sLast;
  logic                 sReady;

  modport master (output sValid, output sData, output sLast, input sReady);
  modport slave  (input sValid, input sData, input sLast, output sReady);
endinterface

// File: rtl/spi_coeff_tx_clk_tick.sv
// Half-period timer: counts ClkDiv cycles and flags the last one; restart_i rewinds it.
module spi_clk_tick
  import fir_engine_pkg::*;
#(
  parameter int ClkDiv = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CntW = cnt_width(ClkDiv);
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_coeff_tx.sv
// SPI mode-0 master that serialises coefficient words MSB-first, one cs-low frame per set.
// Optional frame-length check and lenErr output when SPI_COEFF_TX_LENCHK_EN is defined.
module spi_coeff_tx
  import fir_engine_pkg::*;
#(
  parameter int NTaps     = 13,
  parameter int DataWidth = 8,
  parameter int ClkDiv    = 2
) (
  input  logic           clk,
  input  logic           reset,
  spi_coeff_tx_if.slave  s,
  output logic           cs,
  output logic           spiClk,
  output logic           mosi,
  output logic           busy,
  output logic           done
`ifdef SPI_COEFF_TX_LENCHK_EN
  , output logic         lenErr
`endif
);

  localparam int BitCntW = cnt_width(DataWidth + 1);
  localparam logic [BitCntW-1:0] BitLast = BitCntW'(DataWidth - 1);

  if (ClkDiv < 1 || DataWidth < 2 || NTaps < 1) begin : g_param_err
    $error("spi_coeff_tx: illegal parameter value");
  end

  spi_tx_state_t        state_q, state_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 last_q, last_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 phase_q, phase_d;
  logic                 done_q, done_d;
  logic                 tick, restart, in_accept, ready, hs;

  assign in_accept = (state_q == IDLE) || (state_q == NEXT);
  assign ready     = ~reset & in_accept;
  assign s.sReady  = ready;
  assign hs        = s.sValid & ready;

  // Every state starts its own half-period from zero; IDLE/NEXT keep it parked.
  assign restart = (state_d != state_q) || in_accept;

  spi_clk_tick #(.ClkDiv(ClkDiv)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE, NEXT: begin
        if (hs) begin
          state_d   = SHIFT;
          shift_d   = s.sData;
          last_d    = s.sLast;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            // The final bit stays on mosi so NEXT can hold it.
            if (bit_cnt_q == BitLast) begin
              bit_cnt_d = '0;
              state_d   = last_q ? HOLD : NEXT;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shift_d   = shift_q << 1;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = GAP;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      done_q    <= done_d;
    end
  end

  assign cs     = ((state_q == SHIFT) || (state_q == NEXT) || (state_q == HOLD)) ?
                  SPI_CS_ACTIVE : ~SPI_CS_ACTIVE;
  assign spiClk = (state_q == SHIFT) & phase_q;
  assign mosi   = shift_q[DataWidth-1];
  assign busy   = (state_q != IDLE);
  assign done   = done_q;

`ifdef SPI_COEFF_TX_LENCHK_EN
  // One spare count above NTaps so an over-long frame saturates distinctly.
  localparam int WordCntW = cnt_width(NTaps + 2);
  localparam logic [WordCntW-1:0] WordSat = WordCntW'(NTaps + 1);
  localparam logic [WordCntW-1:0] WordExp = WordCntW'(NTaps);

  logic [WordCntW-1:0] word_cnt_q, word_cnt_d;
  logic                len_err_q, len_err_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    len_err_d  = len_err_q;
    if ((state_d == IDLE) && (state_q != IDLE)) word_cnt_d = '0;
    else if (hs && (word_cnt_q != WordSat))     word_cnt_d = word_cnt_q + 1'b1;
    if (done_d)                                 len_err_d = (word_cnt_q != WordExp);
    else if (hs && (state_q == IDLE))           len_err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign lenErr = len_err_q;
`endif

endmodule
